frameblock_scanout: RTL
=======================

Name: frameblock_scanout

Overview:
- Reads a finished frameblock in address order and streams it to the display link as bytes over a valid/ready interface. Optionally writes a background colour back into each location after reading it.
- Sits on the opposite side of the frameblock RAM from the span rasteriser.
- The frame controller starts it only when rasterisation of the block is complete. Frameblock read and write ports are muxed to this block during scanout.

Parameters:
- COLS, 4, number of x columns per block; x occupies fb address bits [9:8]; legal range 1..4.
- ROWS, 240, rows per column; y occupies fb address bits [7:0]; legal range 1..256.
- BG_COLOR, 16'h0000, RGB565 value written back when clearing.
- CLEAR, 1, 1 = write BG_COLOR behind the read; 0 = fb_we held at 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- blk_start  in  1  request to scan out one block; sampled only in IDLE.
- blk_done  out  1  registered; high while IDLE and no start is pending.
- fb_rdaddr  out  10  frameblock read address {x[1:0], y[7:0]}.
- fb_rddata  in  16  RGB565 read data; valid 1 cycle after fb_rdaddr.
- fb_wraddr  out  10  clear-write address.
- fb_wrdata  out  16  clear-write data, always BG_COLOR.
- fb_we  out  1  clear-write enable.
- px_data  out  8  display byte.
- px_valid  out  1  px_data valid.
- px_ready  in  1  sink accepts a byte when px_valid && px_ready.
- px_last  out  1  marks the final byte of the block.

Behaviour:
- Reset (async, rst_n=0) forces the following; release is synchronous to clk:
  - state=IDLE;
  - blk_done=0, px_valid=0, px_last=0, fb_we=0;
  - fb_rdaddr=0, fb_wraddr=0, px_data=0, all internal registers 0.
- Assertion of rst_n=0 mid-frame aborts immediately; no partial byte or write completes after it.
- States: IDLE, FETCH, SEND_HI, SEND_LO.
- IDLE:
  - blk_done=1 every cycle in which blk_start=0.
  - On blk_start=1: blk_done=0 next cycle, x=y=0, go to FETCH.
  - blk_start outside IDLE is ignored.
- FETCH:
  - Drive fb_rdaddr={x,y}.
  - Next cycle, latch fb_rddata into the pixel register and go to SEND_HI.
- Fetch-to-first-byte latency: blk_start sampled at cycle 0 → fb_rdaddr=0 valid at cycle 1 → first px_valid at cycle 3.
- Scan order:
  - y increments 0..ROWS-1 with x held; then y returns to 0 and x increments, up to x=COLS-1.
  - Addresses y≥ROWS are never issued; e.g. 0x0EF is followed by 0x100.
- SEND_HI:
  - px_data=pixel[15:8], px_valid=1.
  - In the first SEND_HI cycle of each pixel:
    - if more pixels remain, issue the prefetch read of the next address and capture its data the following cycle into a pending register;
    - if CLEAR=1, pulse fb_we=1 for exactly one cycle with fb_wraddr set to the address just captured.
  - On handshake, go to SEND_LO.
- SEND_LO:
  - px_data=pixel[7:0], px_valid=1.
  - px_last=1 only on the low byte of the pixel at (COLS-1, ROWS-1).
  - On handshake:
    - if last, go to IDLE (blk_done=1 the next cycle);
    - else load pending into pixel and go to SEND_HI, with no FETCH cycle.
- Throughput: one byte per clock when px_ready is held high, after the initial fetch.
- Handshake rules:
  - px_data and px_last stay stable while px_valid=1 && px_ready=0.
  - px_valid never drops without a handshake.
  - px_ready is ignored when px_valid=0.
- Byte count: exactly 2*COLS*ROWS bytes per block (1920 at defaults), big-endian per pixel.
- Each address is read exactly once and cleared exactly once per block. Each clear follows that address's read capture.
- Single-pixel block (COLS=1, ROWS=1): no prefetch; 2 bytes; px_last on the second byte.

Test Plan:
- Full block, defaults, px_ready=1, fb[a]=a:
  - 1920 bytes; byte pairs reproduce {x,y} addresses; 0x00EF is followed by 0x0100;
  - px_last only on byte 1920; blk_done high 1 cycle after it.
- Random px_ready backpressure (~50% duty) on the same pattern:
  - identical byte stream;
  - px_data/px_last never change while valid && !ready.
- CLEAR=1, BG_COLOR=16'hF800:
  - 960 fb_we pulses total, one per address;
  - RAM all 0xF800 afterward; no address written before it is read.
  - With CLEAR=0: fb_we is never 1.
- blk_start held high throughout the frame:
  - exactly one scan, no restart mid-frame;
  - a second scan starts from the IDLE cycle after completion.
- rst_n=0 asserted mid-frame at byte 500:
  - all outputs are reset values in the same cycle;
  - after release, blk_done=1 and a new blk_start rescans from address 0.
- COLS=1, ROWS=1:
  - first px_valid 3 cycles after blk_start; 2 bytes;
  - px_last on the second byte; one fb_we pulse.

Source files
------------

// File: rtl/frameblock_scanout.sv
`default_nettype none
// ============================================================================
// Module   : frameblock_scanout
// Purpose  : Reads a finished frameblock in {x,y} address order and streams
//            each RGB565 pixel as two bytes (high byte first) over a
//            valid/ready link. Optionally writes BG_COLOR back into every
//            location once its read data has been captured.
// Revision : 1.0 - initial release
// ============================================================================
module frameblock_scanout #(
    parameter int          COLS     = 4,
    parameter int          ROWS     = 240,
    parameter logic [15:0] BG_COLOR = 16'h0000,
    parameter bit          CLEAR    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        blk_start,
    output logic        blk_done,
    output logic [9:0]  fb_rdaddr,
    input  logic [15:0] fb_rddata,
    output logic [9:0]  fb_wraddr,
    output logic [15:0] fb_wrdata,
    output logic        fb_we,
    output logic [7:0]  px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic        px_last
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_SEND_HI = 2'd2,
        S_SEND_LO = 2'd3
    } state_t;

    localparam logic [1:0] c_X_LAST = 2'(COLS - 1);
    localparam logic [7:0] c_Y_LAST = 8'(ROWS - 1);

    // Scan order: y runs fastest; rows beyond ROWS-1 are skipped.
    function automatic logic [9:0] next_addr(input logic [9:0] a);
        if (a[7:0] == c_Y_LAST) begin
            return {a[9:8] + 2'd1, 8'd0};
        end
        return {a[9:8], a[7:0] + 8'd1};
    endfunction

    function automatic logic is_last(input logic [9:0] a);
        return (a == {c_X_LAST, c_Y_LAST});
    endfunction

    state_t      state_q, state_d;
    logic [9:0]  cur_q, cur_d;        // address of the pixel being fetched/sent
    logic [9:0]  rdaddr_q, rdaddr_d;
    logic [9:0]  wraddr_q, wraddr_d;
    logic        we_q, we_d;
    logic [15:0] pix_q, pix_d;        // pixel on the output
    logic [15:0] pend_q, pend_d;      // prefetched next pixel
    logic        first_q, first_d;    // first SEND_HI cycle of a pixel
    logic        pfcap_q, pfcap_d;    // fb_rddata carries prefetch data now
    logic        fph_q, fph_d;        // FETCH phase: 0 = address out, 1 = capture
    logic        done_q, done_d;

    logic [9:0]  w_nxt;
    logic [9:0]  w_nxt2;
    logic        w_cur_last;
    logic        w_nxt_last;
    logic        w_hs;

    assign w_nxt      = next_addr(cur_q);
    assign w_nxt2     = next_addr(w_nxt);
    assign w_cur_last = is_last(cur_q);
    assign w_nxt_last = is_last(w_nxt);
    assign w_hs       = px_valid && px_ready;

    assign blk_done  = done_q;
    assign fb_rdaddr = rdaddr_q;
    assign fb_wraddr = wraddr_q;
    assign fb_wrdata = BG_COLOR;
    assign fb_we     = we_q;
    assign px_valid  = (state_q == S_SEND_HI) || (state_q == S_SEND_LO);
    assign px_last   = (state_q == S_SEND_LO) && w_cur_last;
    assign px_data   = (state_q == S_SEND_HI) ? pix_q[15:8] :
                       (state_q == S_SEND_LO) ? pix_q[7:0]  : 8'h00;

    // Next-state and datapath decisions for every register.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        rdaddr_d = rdaddr_q;
        wraddr_d = wraddr_q;
        we_d     = 1'b0;
        pix_d    = pix_q;
        pend_d   = pfcap_q ? fb_rddata : pend_q;
        first_d  = 1'b0;
        pfcap_d  = 1'b0;
        fph_d    = fph_q;

        case (state_q)
            S_IDLE: begin
                if (blk_start) begin
                    state_d  = S_FETCH;
                    cur_d    = 10'd0;
                    rdaddr_d = 10'd0;
                    fph_d    = 1'b0;
                end
            end
            S_FETCH: begin
                if (!fph_q) begin
                    fph_d = 1'b1;
                end else begin
                    // Data for cur is on fb_rddata; start sending and prefetch.
                    pix_d    = fb_rddata;
                    state_d  = S_SEND_HI;
                    first_d  = 1'b1;
                    we_d     = CLEAR;
                    wraddr_d = cur_q;
                    if (!w_cur_last) begin
                        rdaddr_d = w_nxt;
                    end
                end
            end
            S_SEND_HI: begin
                if (first_q && !w_cur_last) begin
                    pfcap_d = 1'b1;
                end
                if (w_hs) begin
                    state_d = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (w_hs) begin
                    if (w_cur_last) begin
                        state_d = S_IDLE;
                    end else begin
                        // Prefetch may land in this very cycle, so bypass it.
                        pix_d    = pfcap_q ? fb_rddata : pend_q;
                        cur_d    = w_nxt;
                        state_d  = S_SEND_HI;
                        first_d  = 1'b1;
                        we_d     = CLEAR;
                        wraddr_d = w_nxt;
                        if (!w_nxt_last) begin
                            rdaddr_d = w_nxt2;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address, pixel and handshake-support registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q    <= 10'd0;
            rdaddr_q <= 10'd0;
            wraddr_q <= 10'd0;
            we_q     <= 1'b0;
            pix_q    <= 16'd0;
            pend_q   <= 16'd0;
            first_q  <= 1'b0;
            pfcap_q  <= 1'b0;
            fph_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cur_q    <= cur_d;
            rdaddr_q <= rdaddr_d;
            wraddr_q <= wraddr_d;
            we_q     <= we_d;
            pix_q    <= pix_d;
            pend_q   <= pend_d;
            first_q  <= first_d;
            pfcap_q  <= pfcap_d;
            fph_q    <= fph_d;
            done_q   <= done_d;
        end
    end

endmodule
`default_nettype wire
